// File: rtl/packet_xor_recover_if.sv
// packet_xor_recover_if: job start, input beat and result streams of the XOR recovery accumulator
interface packet_xor_recover_if #(parameter int MASK_W = 128, parameter int W = 4, parameter int PACKET_LENGTH = 2);
  localparam int PW = W * PACKET_LENGTH;
  localparam int CW = $clog2(MASK_W + 1);
  logic start;
  logic [MASK_W-1:0] mask;
  logic in_valid;
  logic in_ready;
  logic [PW-1:0] in_packet;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [PW-1:0] out_packet;
  logic [CW-1:0] out_count;
  logic out_err;
  logic busy;
  modport master (output start, mask, in_valid, in_packet, in_last, out_ready,
                  input in_ready, out_valid, out_packet, out_count, out_err, busy);
  modport slave (input start, mask, in_valid, in_packet, in_last, out_ready,
                 output in_ready, out_valid, out_packet, out_count, out_err, busy);
endinterface

// File: rtl/packet_xor_recover.sv
// packet_xor_recover: serial mask-selected XOR of surviving packets to rebuild an erased packet
module packet_xor_recover #(
  parameter int MASK_W = 128,
  parameter int W = 4,
  parameter int PACKET_LENGTH = 2
) (
  input logic clk,
  input logic rst_n,
  packet_xor_recover_if.slave bus
);
  localparam int PW = W * PACKET_LENGTH;
  localparam int IW = MASK_W > 1 ? $clog2(MASK_W) : 1;
  localparam int CW = $clog2(MASK_W + 1);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, next;
  logic [MASK_W-1:0] mask_q;
  logic [PW-1:0] acc;
  logic [IW-1:0] idx;
  logic [CW-1:0] count;
  logic err;
  logic fire, at_end;
  assign fire = state == ACCUM && bus.in_valid;
  assign at_end = idx == IW'(MASK_W - 1);
  always_comb begin
    next = state;
    next = state == IDLE  ? (bus.start ? ACCUM : IDLE) :
           state == ACCUM ? (fire && (bus.in_last || at_end) ? DONE : ACCUM) :
                            (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // err is rewritten every beat but can only be set on the forced final beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mask_q <= '0;
      acc <= '0;
      idx <= '0;
      count <= '0;
      err <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      mask_q <= bus.mask;
      acc <= '0;
      idx <= '0;
      count <= '0;
      err <= 1'b0;
    end else if (fire) begin
      acc <= mask_q[idx] ? acc ^ bus.in_packet : acc;
      count <= mask_q[idx] ? count + CW'(1) : count;
      idx <= idx + IW'(1);
      err <= at_end && !bus.in_last;
    end
  assign bus.in_ready = state == ACCUM;
  assign bus.busy = state != IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.out_packet = acc;
  assign bus.out_count = count;
  assign bus.out_err = err;
endmodule

// File: tb/tb_packet_xor_recover.sv
// tb_packet_xor_recover: directed and random jobs checked against an array-based XOR reference
module tb_packet_xor_recover;
  localparam int MASK_W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  logic [7:0] beats[$];
  packet_xor_recover_if #(.MASK_W(MASK_W), .W(4), .PACKET_LENGTH(2)) bus ();
  packet_xor_recover #(.MASK_W(MASK_W), .W(4), .PACKET_LENGTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_out_packet"}, 32'(bus.out_packet), 0);
    chk({tag, "_out_count"}, 32'(bus.out_count), 0);
    chk({tag, "_out_err"}, 32'(bus.out_err), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  task automatic job(input logic [3:0] m, input bit has_last, input int gap_pct, input int hold);
    int n = beats.size();
    logic [7:0] ep = 8'h00;
    int ec = 0;
    bit ee = !has_last && n >= MASK_W;
    for (int i = 0; i < n && i < MASK_W; i++)
      if (m[i]) begin
        ep ^= beats[i];
        ec++;
      end
    @(negedge clk);
    chk("idle_ready", 32'(bus.in_ready), 0);
    bus.start = 1'b1;
    bus.mask = m;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_ready", 32'(bus.in_ready), 1);
    chk("start_busy", 32'(bus.busy), 1);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 6 && $urandom_range(0, 99) < gap_pct; g++) begin
        bus.in_valid = 1'b0;
        bus.in_packet = 8'($urandom);
        @(negedge clk);
      end
      chk("beat_ready", 32'(bus.in_ready), 1);
      chk("early_valid", 32'(bus.out_valid), 0);
      bus.in_valid = 1'b1;
      bus.in_packet = beats[i];
      bus.in_last = has_last && i == n - 1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    chk("done_valid", 32'(bus.out_valid), 1);
    chk("done_packet", 32'(bus.out_packet), 32'(ep));
    chk("done_count", 32'(bus.out_count), 32'(ec));
    chk("done_err", 32'(bus.out_err), 32'(ee));
    chk("done_ready", 32'(bus.in_ready), 0);
    for (int h = 0; h < hold; h++) begin
      bus.start = 1'b1;
      bus.mask = 4'($urandom);
      bus.in_valid = 1'b1;
      bus.in_packet = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_packet", 32'(bus.out_packet), 32'(ep));
      chk("hold_count", 32'(bus.out_count), 32'(ec));
      chk("hold_ready", 32'(bus.in_ready), 0);
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("handshake_valid", 32'(bus.out_valid), 0);
    chk("handshake_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mask = '0;
    bus.in_valid = 1'b0;
    bus.in_packet = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    beats = '{8'h3C, 8'hFF, 8'hA5, 8'h0F};
    job(4'b0101, 1, 0, 0);
    beats = '{8'h01, 8'h02, 8'h04, 8'h08};
    job(4'b1111, 0, 0, 0);
    job(4'b1111, 1, 0, 0);
    beats = '{8'hAA, 8'h55};
    job(4'b0000, 1, 0, 0);
    beats = '{8'h3C, 8'hFF, 8'hA5, 8'h0F};
    job(4'b0101, 1, 0, 5);
    beats = '{8'h11, 8'h22, 8'h44};
    job(4'b0110, 1, 0, 0);
    beats = '{8'h3C, 8'hFF, 8'hA5, 8'h0F};
    job(4'b0101, 1, 60, 0);
    job(4'b0101, 1, 60, 2);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mask = 4'b1111;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_packet = 8'h3C;
    @(negedge clk);
    bus.in_packet = 8'hFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_reset_count", 32'(bus.out_count), 2);
    rst_n = 1'b0;
    #1;
    chk_zero("midjob_reset");
    @(negedge clk);
    rst_n = 1'b1;
    beats = '{8'h11, 8'h22};
    job(4'b0010, 1, 0, 0);
    for (int r = 0; r < 20; r++) begin
      int n = $urandom_range(1, MASK_W);
      bit hl = n < MASK_W ? 1'b1 : 1'($urandom_range(0, 1));
      beats.delete();
      for (int i = 0; i < n; i++) beats.push_back(8'($urandom));
      job(4'($urandom), hl, $urandom_range(0, 70), $urandom_range(0, 3));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/packet_xor_recover.md
# packet_xor_recover

Sequential erasure-recovery accumulator for the decode path of the EC accelerator. It receives surviving packets one per beat over a valid/ready stream and XORs those selected by a latched participation mask into a running accumulator. When the job ends it presents the rebuilt packet on a valid/ready output. It performs the same mask-selected XOR as the encode-side XOR trees, serialised in time for the decoder side.

## Interface
- MASK_W, 128, maximum packets per job; width of the participation mask
- W, 4, rows (words) per packet
- PACKET_LENGTH, 2, bits per row; packet width is W*PACKET_LENGTH
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begins a job; honoured only in IDLE
- mask  in  MASK_W  bit j = 1 means beat j is XORed; sampled on an accepted start
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_packet  in  W*PACKET_LENGTH  packet; row r occupies bits [r*PACKET_LENGTH +: PACKET_LENGTH]
- in_last  in  1  final beat of the job
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_packet  out  W*PACKET_LENGTH  XOR of all selected beats
- out_count  out  $clog2(MASK_W+1)  number of beats XORed
- out_err  out  1  job force-terminated at MASK_W beats without in_last
- busy  out  1  high in ACCUM and DONE

## Operation
- One clock domain, clocked on clk. Reset is asynchronous and active-low (rst_n).
- FSM states: IDLE, ACCUM, DONE.
- IDLE: in_ready=0, out_valid=0.
  - On start: latch mask; clear the accumulator, beat index idx and count; go to ACCUM.
- ACCUM: in_ready=1. On each accepted beat:
  - If mask[idx]=1: acc ^= in_packet and count++.
  - idx++.
  - If in_last=1, or idx==MASK_W-1, go to DONE with out_valid=1.
  - out_err = (idx==MASK_W-1 && !in_last).
- DONE: in_ready=0. out_packet, out_count and out_err are held stable while out_valid=1.
  - On out_valid && out_ready: go to IDLE.
- start in ACCUM or DONE is ignored and has no side effect.
- XOR is bitwise across all rows. There is no carry and no row interaction.
- mask bits at indices at or beyond the job length are don't-care.
- Reset (asserted at any time, including mid-job): state=IDLE; acc, idx, count and the latched mask = 0. All outputs go to 0: in_ready, out_valid, out_packet, out_count, out_err, busy. A partial job is discarded.

## Timing
- start sampled at cycle t: in_ready=1 from cycle t+1.
- Final beat accepted at cycle t: out_valid=1 from cycle t+1. Latency is 1 cycle.
- Throughput is one beat per cycle in ACCUM. in_valid gaps stall without corrupting state.
- out_valid, once asserted, stays high until the handshake completes. out_packet must not change while waiting.
- Output handshake at cycle t: IDLE at t+1, so a new start is honoured at t+1. The minimum job turnaround is beats + 2 cycles.
- All outputs are registered. in_ready and busy decode from the state register only.

## Test plan
- MASK_W=4, W=4, PACKET_LENGTH=2. mask=4'b0101; beats 0x3C, 0xFF, 0xA5, 0x0F (last on 4th) -> out_packet=0x99, out_count=2, out_err=0, out_valid one cycle after the 4th beat.
- mask=4'b1111; beats 0x01, 0x02, 0x04, 0x08 with in_last never asserted -> forced termination after the 4th beat, out_packet=0x0F, out_count=4, out_err=1. Repeat with in_last on the 4th beat -> out_err=0.
- mask=4'b0000; two beats 0xAA, 0x55 (last on 2nd) -> out_packet=0x00, out_count=0, out_err=0.
- Hold out_ready=0 for 5 cycles in DONE, pulse start and drive in_valid -> in_ready stays 0, outputs unchanged, start ignored. Raise out_ready -> IDLE next cycle. A new start then yields an independent result with no residue from the prior job.
- Random in_valid gaps (≥50% idle) over the first scenario -> identical result 0x99, count 2.
- Assert rst_n=0 after 2 beats of a job -> all outputs 0 immediately. After release, a new job with mask=4'b0010 and beats 0x11, 0x22 (last) -> out_packet=0x22, count=1.
